// File: rtl/tiny16_sysctl_pkg.sv
`timescale 1ns/100ps
// Shared definitions for the Tiny16 system controller: FSM states, interrupt
// source indices and the acknowledge priority helper.
package tiny16_sysctl_pkg;

  localparam int unsigned NUM_IRQ   = 2;
  localparam int unsigned IRQ_TIMER = 0;
  localparam int unsigned IRQ_EXT   = 1;

  typedef enum logic [1:0] {
    ST_RESET_HOLD = 2'd0,
    ST_RUN        = 2'd1,
    ST_WFI_SLEEP  = 2'd2,
    ST_HALTED     = 2'd3
  } state_e;

  // Selects the single pending bit an acknowledge retires; timer outranks external.
  function automatic logic [NUM_IRQ-1:0] ack_mask(input logic [NUM_IRQ-1:0] pend);
    logic [NUM_IRQ-1:0] m;
    m = '0;
    if (pend[IRQ_TIMER])    m[IRQ_TIMER] = 1'b1;
    else if (pend[IRQ_EXT]) m[IRQ_EXT]   = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/tiny16_sysctl_if.sv
`timescale 1ns/100ps
// CPU-facing control bundle of the system controller: sleep/halt status and
// acknowledge from the CPU, reset, clock enable and interrupt request to it.
interface tiny16_sysctl_if;
  import tiny16_sysctl_pkg::*;

  logic               nhlt;
  logic               nwfi;
  logic               irq_ack;
  logic               cpu_nreset;
  logic               cpu_clk_en;
  logic               irq;
  logic [NUM_IRQ-1:0] irq_src;

  modport master (
    input  nhlt, nwfi, irq_ack,
    output cpu_nreset, cpu_clk_en, irq, irq_src
  );

  modport slave (
    output nhlt, nwfi, irq_ack,
    input  cpu_nreset, cpu_clk_en, irq, irq_src
  );

endinterface

// File: rtl/tiny16_edge_sync.sv
`timescale 1ns/100ps
// Two-flop synchroniser for an asynchronous input followed by a rising-edge
// detector; rise_c is a one-cycle pulse in the clk domain.
module tiny16_edge_sync (
  input  logic clk,
  input  logic nreset,
  input  logic d,
  output logic rise_c
);

  // [0],[1] synchroniser stages, [2] previous synchronised value
  logic [2:0] sync_q;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) sync_q <= '0;
    else         sync_q <= {sync_q[1:0], d};
  end

  assign rise_c = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/tiny16_sysctl.sv
`timescale 1ns/100ps
// Tiny16 system controller: prescaler, CPU power-on reset, timer and external
// interrupts, WFI/HLT clock gating and status LED.
module tiny16_sysctl
  import tiny16_sysctl_pkg::*;
#(
  parameter int unsigned COUNTER_BITS = 24,
  parameter int unsigned RESET_BIT    = 20,
  parameter int unsigned TIMER_BIT    = 22
) (
  input  logic                   clk,
  input  logic                   nreset,
  tiny16_sysctl_if.master        cpu,
  input  logic                   ext_irq,
  output logic                   led
);

  logic [COUNTER_BITS-1:0] counter;
  logic                    tbit_q;
  logic                    tick_c;
  logic                    ext_edge_c;

  state_e             state, state_next;
  logic [NUM_IRQ-1:0] pend_q, pend_next;
  logic [NUM_IRQ-1:0] set_c, clr_c;
  logic               led_q, led_next;
  logic               cpu_nreset_q, cpu_nreset_next;
  logic               cpu_clk_en_q, cpu_clk_en_next;
  logic               irq_q, irq_next;

  // Free-running prescaler and timer-bit history
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      counter <= '0;
      tbit_q  <= 1'b0;
    end else begin
      counter <= counter + COUNTER_BITS'(1);
      tbit_q  <= counter[TIMER_BIT];
    end
  end

  assign tick_c = counter[TIMER_BIT] & ~tbit_q;

  tiny16_edge_sync u_ext_sync (
    .clk    (clk),
    .nreset (nreset),
    .d      (ext_irq),
    .rise_c (ext_edge_c)
  );

  // State and registered outputs
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state        <= ST_RESET_HOLD;
      pend_q       <= '0;
      led_q        <= 1'b0;
      cpu_nreset_q <= 1'b0;
      cpu_clk_en_q <= 1'b1;
      irq_q        <= 1'b0;
    end else begin
      state        <= state_next;
      pend_q       <= pend_next;
      led_q        <= led_next;
      cpu_nreset_q <= cpu_nreset_next;
      cpu_clk_en_q <= cpu_clk_en_next;
      irq_q        <= irq_next;
    end
  end

  always_comb begin
    state_next = state;
    pend_next  = pend_q;
    led_next   = led_q;
    set_c      = '0;
    clr_c      = '0;

    unique case (state)
      ST_RESET_HOLD: if (counter[RESET_BIT]) state_next = ST_RUN;
      ST_RUN: begin
        if (!cpu.nhlt)                      state_next = ST_HALTED;
        else if (!cpu.nwfi && pend_q == '0) state_next = ST_WFI_SLEEP;
      end
      ST_WFI_SLEEP:  if (pend_q != '0) state_next = ST_RUN;
      ST_HALTED:     state_next = ST_HALTED;
      default:       state_next = ST_RESET_HOLD;
    endcase

    // Sources only latch while the CPU is alive; a same-cycle set beats the ack clear
    if (state == ST_RUN || state == ST_WFI_SLEEP) begin
      set_c[IRQ_TIMER] = tick_c;
      set_c[IRQ_EXT]   = ext_edge_c;
      if (cpu.irq_ack) clr_c = ack_mask(pend_q);
      pend_next = (pend_q & ~clr_c) | set_c;
      if (tick_c) led_next = ~led_q;
    end else begin
      pend_next = '0;
    end

    if (state_next == ST_HALTED) begin
      pend_next = '0;
      led_next  = 1'b1;
    end

    cpu_nreset_next = (state_next != ST_RESET_HOLD);
    cpu_clk_en_next = !(state_next inside {ST_WFI_SLEEP, ST_HALTED});
    irq_next        = (|pend_next) && (state_next inside {ST_RUN, ST_WFI_SLEEP});
  end

  assign cpu.cpu_nreset = cpu_nreset_q;
  assign cpu.cpu_clk_en = cpu_clk_en_q;
  assign cpu.irq        = irq_q;
  assign cpu.irq_src    = pend_q;
  assign led            = led_q;

endmodule

// File: tb/tb_tiny16_sysctl.sv
`timescale 1ns/100ps
// Bench for tiny16_sysctl with a small prescaler; edges are counted from
// nreset release and outputs are sampled on the falling clock edge.
module tb_tiny16_sysctl;
  import tiny16_sysctl_pkg::*;

  logic clk     = 1'b0;
  logic nreset  = 1'b1;
  logic ext_irq = 1'b0;
  logic led;

  tiny16_sysctl_if cpu_if ();

  tiny16_sysctl #(
    .COUNTER_BITS (8),
    .RESET_BIT    (2),
    .TIMER_BIT    (7)
  ) dut (
    .clk     (clk),
    .nreset  (nreset),
    .cpu     (cpu_if),
    .ext_irq (ext_irq),
    .led     (led)
  );

  always #1 clk = ~clk;

  // Expected output vector packing: {cpu_nreset, cpu_clk_en, irq, irq_src[1:0], led}
  typedef struct {
    int         sc;
    int         edge_n;
    logic       nhlt;
    logic       nwfi;
    logic       ack;
    logic       ext;
    logic [5:0] exp;
  } vec_t;

  vec_t       tbl[$];
  logic [5:0] sb_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         ecnt     = 0;

  function automatic logic [5:0] outs();
    return {cpu_if.cpu_nreset, cpu_if.cpu_clk_en, cpu_if.irq, cpu_if.irq_src, led};
  endfunction

  task automatic check(input string name, input logic [5:0] exp);
    logic [5:0] got;
    got = outs();
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got nrst/en/irq/src/led=%b required %b", name, got, exp);
    end
  endtask

  task automatic add(input int sc, input int e, input logic h, input logic w,
                     input logic a, input logic x, input logic [5:0] exp);
    vec_t v;
    v.sc = sc; v.edge_n = e; v.nhlt = h; v.nwfi = w; v.ack = a; v.ext = x; v.exp = exp;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic h, input logic w, input logic a, input logic x);
    cpu_if.nhlt    = h;
    cpu_if.nwfi    = w;
    cpu_if.irq_ack = a;
    ext_irq        = x;
  endtask

  task automatic run_to(input int e);
    while (ecnt < e) begin
      @(posedge clk);
      ecnt++;
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    nreset = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("reset_values", 6'b010000);
    nreset = 1'b1;
    ecnt   = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev_sc;
    drive(1'b1, 1'b1, 1'b0, 1'b0);

    //  sc  edge  nhlt nwfi ack  ext   {nrst,en,irq,src,led}
    // reset release
    add(1,   0, 1, 1, 0, 0, 6'b010000);
    add(1,   4, 1, 1, 0, 0, 6'b010000);
    add(1,   5, 1, 1, 0, 0, 6'b110000);
    add(1,   6, 1, 1, 0, 0, 6'b110000);
    // timer tick, acknowledge, next tick
    add(2, 128, 1, 1, 0, 0, 6'b110000);
    add(2, 129, 1, 1, 0, 0, 6'b111011);
    add(2, 139, 1, 1, 1, 0, 6'b111011);
    add(2, 140, 1, 1, 0, 0, 6'b110001);
    add(2, 384, 1, 1, 0, 0, 6'b110001);
    add(2, 385, 1, 1, 0, 0, 6'b111010);
    // WFI sleep and wake (nwfi held low across the sleep)
    add(3,  19, 1, 0, 0, 0, 6'b110000);
    add(3,  20, 1, 0, 0, 0, 6'b100000);
    add(3, 129, 1, 0, 0, 0, 6'b101011);
    add(3, 130, 1, 0, 0, 0, 6'b111011);
    add(3, 131, 1, 1, 0, 0, 6'b111011);
    // external + timer priority; ack colliding with the second tick
    add(4, 125, 1, 1, 0, 1, 6'b110000);
    add(4, 128, 1, 1, 0, 1, 6'b111100);
    add(4, 129, 1, 1, 0, 1, 6'b111111);
    add(4, 384, 1, 1, 1, 1, 6'b111111);
    add(4, 385, 1, 1, 1, 1, 6'b111110);
    add(4, 386, 1, 1, 1, 1, 6'b111100);
    add(4, 387, 1, 1, 0, 1, 6'b110000);
    // halt has priority over wfi; tick and external edge ignored when halted
    add(5,  29, 0, 0, 0, 0, 6'b110000);
    add(5,  30, 0, 0, 0, 0, 6'b100001);
    add(5, 100, 0, 0, 0, 1, 6'b100001);
    add(5, 129, 0, 0, 0, 1, 6'b100001);

    prev_sc = 0;
    foreach (tbl[i]) begin
      if (tbl[i].sc != prev_sc) begin
        do_reset();
        prev_sc = tbl[i].sc;
      end
      sb_q.push_back(tbl[i].exp);
      run_to(tbl[i].edge_n);
      check($sformatf("sc%0d_edge%0d", tbl[i].sc, tbl[i].edge_n), sb_q.pop_front());
      drive(tbl[i].nhlt, tbl[i].nwfi, tbl[i].ack, tbl[i].ext);
    end

    // Asynchronous reset just after edge 200 while halted, then release again
    run_to(199);
    @(posedge clk);
    #0.5 nreset = 1'b0;
    #0.2 check("async_reset_halted", 6'b010000);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    nreset = 1'b1;
    ecnt   = 0;
    sb_q.push_back(6'b010000);
    run_to(4);
    check("rerelease_edge4", sb_q.pop_front());
    sb_q.push_back(6'b110000);
    run_to(5);
    check("rerelease_edge5", sb_q.pop_front());

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
